// File: rtl/pad_cfg_if.sv
// Serial configuration handshake between a frame source (master) and
// the pad configuration controller (slave).
interface pad_cfg_if;
   logic cfg_start;
   logic cfg_valid;
   logic cfg_bit;
   logic cfg_ready;
   logic cfg_err_clr;
   logic cfg_busy;
   logic cfg_done;
   logic cfg_err;

   modport master (
      output cfg_start, cfg_valid, cfg_bit, cfg_err_clr,
      input  cfg_ready, cfg_busy, cfg_done, cfg_err
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_bit, cfg_err_clr,
      output cfg_ready, cfg_busy, cfg_done, cfg_err
   );
endinterface

// File: rtl/pad_cfg_ctrl.sv
// Pad configuration controller: receives a serial frame of per-pad
// control fields plus an even-parity bit, commits it atomically to the
// active pad controls, and synchronises raw pad inputs into clk.
module pad_cfg_ctrl #(
   parameter int NUM_BIDIR_PADS = 4,
   parameter int NUM_INPUT_PADS = 4,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   pad_cfg_if.slave                  cfg,
   output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
   output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
   output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
   output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
   output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
   output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
   input  logic [NUM_INPUT_PADS-1:0] input_raw,
   output logic [NUM_INPUT_PADS-1:0] input_sync,
   input  logic [NUM_BIDIR_PADS-1:0] bidir_raw,
   output logic [NUM_BIDIR_PADS-1:0] bidir_sync
);

   localparam int W  = 6 * NUM_BIDIR_PADS;
   localparam int CW = $clog2(W + 1);
   localparam int NS = NUM_INPUT_PADS + NUM_BIDIR_PADS;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] COMMIT = 2'd3;

   localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

   // Shadow encoding that matches the reset state of the active controls:
   // only the input-enable field (bit 3 of each 6-bit pad field) is set.
   function automatic logic [W-1:0] ctrl_reset_word();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
         r[6*i+3] = 1'b1;
      end
      return r;
   endfunction

   localparam logic [W-1:0] SHADOW_RST = ctrl_reset_word();

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  shadow;
   logic          err;
   logic          accept;
   logic          parity_bad;

   // cfg_start takes priority over a bit offered in the same cycle.
   assign accept     = cfg.cfg_valid & cfg.cfg_ready & ~cfg.cfg_start;
   assign parity_bad = (state == PARITY) & accept & ((^shadow) ^ cfg.cfg_bit);

   assign cfg.cfg_ready = (state == SHIFT) | (state == PARITY);
   assign cfg.cfg_busy  = (state != IDLE);
   assign cfg.cfg_done  = (state == COMMIT);
   assign cfg.cfg_err   = err;

   // Frame sequencing: state, bit counter and shadow shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         shadow <= SHADOW_RST;
      end else begin
         case (state)
            IDLE: begin
               if (cfg.cfg_start) begin
                  state <= SHIFT;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               if (cfg.cfg_start) begin
                  cnt <= '0;
               end else if (accept) begin
                  shadow <= {shadow[W-2:0], cfg.cfg_bit};
                  cnt    <= cnt + CW'(1);
                  if (cnt == LAST_IDX) begin
                     state <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (cfg.cfg_start) begin
                  state <= SHIFT;
                  cnt   <= '0;
               end else if (accept) begin
                  state <= parity_bad ? IDLE : COMMIT;
               end
            end
            COMMIT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Sticky parity error; a new error in the same cycle beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (parity_bad) begin
         err <= 1'b1;
      end else if (cfg.cfg_err_clr) begin
         err <= 1'b0;
      end
   end

   // Active controls load from the shadow only on the edge leaving COMMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bidir_oe <= '0;
         bidir_cs <= '0;
         bidir_sl <= '0;
         bidir_ie <= '1;
         bidir_pu <= '0;
         bidir_pd <= '0;
      end else if (state == COMMIT) begin
         for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
            bidir_oe[i] <= shadow[6*i+0];
            bidir_cs[i] <= shadow[6*i+1];
            bidir_sl[i] <= shadow[6*i+2];
            bidir_ie[i] <= shadow[6*i+3];
            bidir_pu[i] <= shadow[6*i+4];
            bidir_pd[i] <= shadow[6*i+5];
         end
      end
   end

   logic [SYNC_STAGES-1:0][NS-1:0] sync_p;

   // Multi-flop synchroniser chain for every raw pad input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p <= '0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], {bidir_raw, input_raw}};
      end
   end

   assign input_sync = sync_p[SYNC_STAGES-1][NUM_INPUT_PADS-1:0];
   assign bidir_sync = sync_p[SYNC_STAGES-1][NS-1:NUM_INPUT_PADS];

endmodule
